// File: rtl/fifo_id_skid_stage_pkg.sv
// Shared constants, state encoding and payload-width helper for the fetch-buffer to decode skid stage.
package fifo_id_skid_stage_pkg;

  localparam logic [31:0] INST_NOP = 32'h0340_0000;
  localparam logic [31:0] PC_RESET = 32'h1c00_0000;

  typedef enum logic [1:0] {
    FIDS_EMPTY = 2'd0,
    FIDS_ONE   = 2'd1,
    FIDS_TWO   = 2'd2
  } fids_state_e;

  function automatic int unsigned fids_payload_w(input int unsigned lanes,
                                                 input int unsigned inst_w,
                                                 input int unsigned addr_w,
                                                 input int unsigned exc_w);
    return lanes * (inst_w + 1) + 2 * addr_w + exc_w + 4;
  endfunction

endpackage

// File: rtl/fifo_id_skid_stage_reg.sv
// Generic enable/clear payload register used for the main and skid entries.
module fids_payload_reg #(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_q <= RST_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/fifo_id_skid_stage.sv
// Fetch-buffer to decode pipeline register with a two-entry skid buffer.
// Optional FIFO_ID_PERF_EN adds stall/bubble performance counters.
module fifo_id_skid_stage
  import fifo_id_skid_stage_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned EXC_W  = 7
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic                    fifo_readygo,
  output logic                    fifo_allowin,
  input  logic [LANES*INST_W-1:0] in_inst,
  input  logic [LANES-1:0]        in_lane_vld,
  input  logic [ADDR_W-1:0]       in_pc,
  input  logic [ADDR_W-1:0]       in_badv,
  input  logic [EXC_W-1:0]        in_exception,
  input  logic [1:0]              in_excp_flag,
  input  logic [1:0]              in_ibar_flag,
  input  logic                    id_allowin,
  output logic                    id_readygo,
  output logic [LANES*INST_W-1:0] out_inst,
  output logic [LANES-1:0]        out_lane_vld,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [ADDR_W-1:0]       out_badv,
  output logic [EXC_W-1:0]        out_exception,
  output logic [1:0]              out_excp_flag,
  output logic [1:0]              out_ibar_flag
`ifdef FIFO_ID_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_bubble_cnt
`endif
);

  localparam int unsigned PW = fids_payload_w(LANES, INST_W, ADDR_W, EXC_W);
  localparam logic [PW-1:0] RST_PAYLOAD = {{LANES{INST_W'(INST_NOP)}}, {LANES{1'b0}},
                                           ADDR_W'(PC_RESET), ADDR_W'(PC_RESET),
                                           {EXC_W{1'b0}}, 4'b0000};

  fids_state_e r_state;
  logic        r_readygo;
  logic        r_allowin;

  logic          w_push;
  logic          w_pop;
  logic          w_main_ld;
  logic          w_main_clr;
  logic          w_skid_ld;
  logic [PW-1:0] w_in;
  logic [PW-1:0] w_main_d;
  logic [PW-1:0] w_main_q;
  logic [PW-1:0] w_skid_q;

  assign w_push = fifo_readygo & r_allowin;
  assign w_pop  = r_readygo & id_allowin;

  assign w_in = {in_inst, in_lane_vld, in_pc, in_badv, in_exception, in_excp_flag, in_ibar_flag};

  // Main entry refills from input (EMPTY, or ONE with pop) or from skid when draining TWO.
  assign w_main_ld  = (w_push && (r_state == FIDS_EMPTY || w_pop)) || (r_state == FIDS_TWO && w_pop);
  assign w_main_clr = flush || (r_state == FIDS_ONE && w_pop && !w_push);
  assign w_skid_ld  = (r_state == FIDS_ONE) && w_push && !w_pop;
  assign w_main_d   = (r_state == FIDS_TWO) ? w_skid_q : w_in;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_state   <= FIDS_EMPTY;
      r_readygo <= 1'b0;
      r_allowin <= 1'b1;
    end else begin
      case (r_state)
        FIDS_EMPTY: begin
          if (w_push) begin
            r_state   <= FIDS_ONE;
            r_readygo <= 1'b1;
          end
        end
        FIDS_ONE: begin
          if (w_push && !w_pop) begin
            r_state   <= FIDS_TWO;
            r_allowin <= 1'b0;
          end else if (w_pop && !w_push) begin
            r_state   <= FIDS_EMPTY;
            r_readygo <= 1'b0;
          end
        end
        FIDS_TWO: begin
          if (w_pop) begin
            r_state   <= FIDS_ONE;
            r_allowin <= 1'b1;
          end
        end
        default: begin
          r_state   <= FIDS_EMPTY;
          r_readygo <= 1'b0;
          r_allowin <= 1'b1;
        end
      endcase
    end
  end

  fids_payload_reg #(.W(PW), .RST_VAL(RST_PAYLOAD)) u_main (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_main_clr),
    .en   (w_main_ld),
    .d    (w_main_d),
    .q    (w_main_q)
  );

  fids_payload_reg #(.W(PW), .RST_VAL(RST_PAYLOAD)) u_skid (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .en   (w_skid_ld),
    .d    (w_in),
    .q    (w_skid_q)
  );

  assign id_readygo   = r_readygo;
  assign fifo_allowin = r_allowin;
  assign {out_inst, out_lane_vld, out_pc, out_badv, out_exception, out_excp_flag, out_ibar_flag} = w_main_q;

`ifdef FIFO_ID_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (r_readygo && !id_allowin) r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (!r_readygo && id_allowin) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt  = r_stall_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fifo_id_skid_stage.sv
// Self-checking bench: directed vector table, random traffic against a 2-deep queue model, perf sequence.
module tb_fifo_id_skid_stage;

  localparam logic [31:0] NOP    = 32'h0340_0000;
  localparam logic [31:0] PC_RST = 32'h1c00_0000;

  typedef struct packed {
    logic [63:0] inst;
    logic [1:0]  lv;
    logic [31:0] pc;
    logic [31:0] badv;
    logic [6:0]  exc;
    logic [1:0]  ef;
    logic [1:0]  ibf;
  } pkt_t;

  typedef struct {
    bit          rstn;
    bit          flush;
    bit          rg;
    bit          ida;
    logic [31:0] pc;
    logic [1:0]  lv;
    logic [31:0] badv;
    logic [6:0]  exc;
    bit          e_rdy;
    bit          e_alw;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn, flush, fifo_readygo, id_allowin;
  logic        fifo_allowin, id_readygo;
  logic [63:0] in_inst, out_inst;
  logic [1:0]  in_lane_vld, out_lane_vld;
  logic [31:0] in_pc, in_badv, out_pc, out_badv;
  logic [6:0]  in_exception, out_exception;
  logic [1:0]  in_excp_flag, in_ibar_flag, out_excp_flag, out_ibar_flag;
`ifdef FIFO_ID_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
  logic [31:0] m_stall = 32'd0, m_bubble = 32'd0;
`endif

  int   errors = 0;
  int   checks = 0;
  pkt_t q[$];
  pkt_t rst_pkt;
  vec_t vt[22];

  always #5 clk = ~clk;

  fifo_id_skid_stage dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .fifo_readygo (fifo_readygo),
    .fifo_allowin (fifo_allowin),
    .in_inst      (in_inst),
    .in_lane_vld  (in_lane_vld),
    .in_pc        (in_pc),
    .in_badv      (in_badv),
    .in_exception (in_exception),
    .in_excp_flag (in_excp_flag),
    .in_ibar_flag (in_ibar_flag),
    .id_allowin   (id_allowin),
    .id_readygo   (id_readygo),
    .out_inst     (out_inst),
    .out_lane_vld (out_lane_vld),
    .out_pc       (out_pc),
    .out_badv     (out_badv),
    .out_exception(out_exception),
    .out_excp_flag(out_excp_flag),
    .out_ibar_flag(out_ibar_flag)
`ifdef FIFO_ID_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] pc, input logic [1:0] lv,
                              input logic [31:0] badv, input logic [6:0] exc);
    pkt_t p;
    p.inst = {pc ^ 32'h2222_0000, pc ^ 32'h0000_1111};
    p.lv   = lv;
    p.pc   = pc;
    p.badv = badv;
    p.exc  = exc;
    p.ef   = pc[3:2];
    p.ibf  = pc[5:4];
    return p;
  endfunction

  function automatic vec_t v(input bit r, input bit f, input bit g, input bit a,
                             input logic [31:0] pc, input logic [1:0] lv,
                             input logic [31:0] badv, input logic [6:0] exc,
                             input bit erdy, input bit ealw, input logic [31:0] epc);
    vec_t x;
    x.rstn = r; x.flush = f; x.rg = g; x.ida = a;
    x.pc = pc; x.lv = lv; x.badv = badv; x.exc = exc;
    x.e_rdy = erdy; x.e_alw = ealw; x.e_pc = epc;
    return x;
  endfunction

  // One clock: drive inputs, advance the queue model, compare all outputs after the edge.
  task automatic step(input bit r, input bit f, input bit g, input bit a, input pkt_t p);
    int   sz;
    pkt_t e;
    @(negedge clk);
    rstn = r; flush = f; fifo_readygo = g; id_allowin = a;
    {in_inst, in_lane_vld, in_pc, in_badv, in_exception, in_excp_flag, in_ibar_flag} = p;
    sz = q.size();
`ifdef FIFO_ID_PERF_EN
    if (!r) begin
      m_stall = 32'd0; m_bubble = 32'd0;
    end else begin
      if (sz > 0 && !a) m_stall++;
      if (sz == 0 && a) m_bubble++;
    end
`endif
    if (!r || f) begin
      q.delete();
    end else begin
      if (sz > 0 && a) q.delete(0);
      if (g && sz < 2) q.push_back(p);
    end
    @(posedge clk);
    #1;
    e = (q.size() > 0) ? q[0] : rst_pkt;
    chk("id_readygo", 160'(id_readygo), 160'(q.size() > 0));
    chk("fifo_allowin", 160'(fifo_allowin), 160'(q.size() < 2));
    chk("payload", 160'({out_inst, out_lane_vld, out_pc, out_badv, out_exception,
                         out_excp_flag, out_ibar_flag}), 160'(e));
`ifdef FIFO_ID_PERF_EN
    chk("perf_stall_cnt", 160'(perf_stall_cnt), 160'(m_stall));
    chk("perf_bubble_cnt", 160'(perf_bubble_cnt), 160'(m_bubble));
`endif
  endtask

  initial begin
    rst_pkt = '{inst: {NOP, NOP}, lv: 2'b00, pc: PC_RST, badv: PC_RST, exc: 7'h0, ef: 2'b00, ibf: 2'b00};
    rstn = 1'b0; flush = 1'b0; fifo_readygo = 1'b0; id_allowin = 1'b0;
    in_inst = '0; in_lane_vld = '0; in_pc = '0; in_badv = '0;
    in_exception = '0; in_excp_flag = '0; in_ibar_flag = '0;

    //        rstn fl rg ida pc            lv     badv          exc    rdy alw out_pc
    vt[0]  = v(0, 0, 0, 0, 32'h0,        2'b11, 32'h0,        7'h0,  0, 1, PC_RST);
    vt[1]  = v(0, 0, 1, 1, 32'h40,       2'b11, 32'h0,        7'h0,  0, 1, PC_RST);
    vt[2]  = v(1, 0, 0, 1, 32'h0,        2'b11, 32'h0,        7'h0,  0, 1, PC_RST);
    vt[3]  = v(1, 0, 1, 1, 32'h1c000000, 2'b11, 32'h1,        7'h0,  1, 1, 32'h1c000000);
    vt[4]  = v(1, 0, 1, 1, 32'h1c000008, 2'b11, 32'h2,        7'h0,  1, 1, 32'h1c000008);
    vt[5]  = v(1, 0, 1, 1, 32'h1c000010, 2'b11, 32'h3,        7'h0,  1, 1, 32'h1c000010);
    vt[6]  = v(1, 0, 0, 1, 32'h0,        2'b11, 32'h0,        7'h0,  0, 1, PC_RST);
    vt[7]  = v(1, 0, 1, 0, 32'h100,      2'b11, 32'h4,        7'h0,  1, 1, 32'h100);
    vt[8]  = v(1, 0, 1, 0, 32'h108,      2'b11, 32'h5,        7'h0,  1, 0, 32'h100);
    vt[9]  = v(1, 0, 1, 0, 32'h110,      2'b11, 32'h6,        7'h0,  1, 0, 32'h100);
    vt[10] = v(1, 0, 0, 1, 32'h0,        2'b11, 32'h0,        7'h0,  1, 1, 32'h108);
    vt[11] = v(1, 0, 0, 1, 32'h0,        2'b11, 32'h0,        7'h0,  0, 1, PC_RST);
    vt[12] = v(1, 0, 1, 0, 32'h180,      2'b10, 32'h7,        7'h1,  1, 1, 32'h180);
    vt[13] = v(1, 0, 1, 0, 32'h188,      2'b11, 32'h8,        7'h2,  1, 0, 32'h180);
    vt[14] = v(1, 1, 1, 0, 32'h200,      2'b11, 32'h9,        7'h3,  0, 1, PC_RST);
    vt[15] = v(1, 0, 0, 1, 32'h0,        2'b11, 32'h0,        7'h0,  0, 1, PC_RST);
    vt[16] = v(1, 0, 1, 0, 32'h300,      2'b01, 32'hdeadbeef, 7'h08, 1, 1, 32'h300);
    vt[17] = v(1, 0, 0, 1, 32'h0,        2'b11, 32'h0,        7'h0,  0, 1, PC_RST);
    vt[18] = v(1, 0, 1, 1, 32'h400,      2'b00, 32'hbad0,     7'h0c, 1, 1, 32'h400);
    vt[19] = v(1, 0, 0, 1, 32'h0,        2'b11, 32'h0,        7'h0,  0, 1, PC_RST);
    vt[20] = v(1, 0, 1, 0, 32'h500,      2'b11, 32'ha,        7'h0,  1, 1, 32'h500);
    vt[21] = v(1, 1, 0, 1, 32'h0,        2'b11, 32'h0,        7'h0,  0, 1, PC_RST);

    for (int i = 0; i < 22; i++) begin
      step(vt[i].rstn, vt[i].flush, vt[i].rg, vt[i].ida, mk(vt[i].pc, vt[i].lv, vt[i].badv, vt[i].exc));
      chk($sformatf("vec%0d rdy", i), 160'(id_readygo), 160'(vt[i].e_rdy));
      chk($sformatf("vec%0d alw", i), 160'(fifo_allowin), 160'(vt[i].e_alw));
      chk($sformatf("vec%0d pc", i), 160'(out_pc), 160'(vt[i].e_pc));
      if (i == 16) begin
        chk("lane_vld 01", 160'(out_lane_vld), 160'(2'b01));
        chk("badv deadbeef", 160'(out_badv), 160'(32'hdeadbeef));
        chk("exception 08", 160'(out_exception), 160'(7'h08));
      end
      if (i == 18) chk("empty-mask packet", 160'(out_lane_vld), 160'(2'b00));
      if (i == 8 || i == 13) chk("out_inst held", 160'(out_inst), 160'(mk(vt[i-1].pc, 2'b0, 32'h0, 7'h0).inst));
      if (i == 14 || i == 21) chk("flush nop", 160'(out_inst), 160'({NOP, NOP}));
    end

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(99, 0) != 0, $urandom_range(19, 0) == 0, $urandom_range(1, 0) == 1,
           $urandom_range(9, 0) < 6,
           mk({$urandom} & 32'hffff_fffc, 2'($urandom), $urandom, 7'($urandom)));
    end

`ifdef FIFO_ID_PERF_EN
    step(0, 0, 0, 0, rst_pkt);
    step(0, 0, 0, 0, rst_pkt);
    step(1, 0, 1, 0, mk(32'h600, 2'b11, 32'h0, 7'h0));
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, rst_pkt);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1, rst_pkt);
    chk("stall=5", 160'(perf_stall_cnt), 160'(32'd5));
    chk("bubble=3", 160'(perf_bubble_cnt), 160'(32'd3));
    step(1, 1, 0, 0, rst_pkt);
    chk("stall kept by flush", 160'(perf_stall_cnt), 160'(32'd5));
    chk("bubble kept by flush", 160'(perf_bubble_cnt), 160'(32'd3));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_id_skid_stage.md
Name: fifo_id_skid_stage

Overview:
- Parametrised fetch-buffer → decode pipeline register with a two-entry skid buffer and a per-lane valid mask.
- Decouples the upstream ready from the downstream allowin, so fifo_allowin is a registered signal.
- Sits between the instruction fetch buffer and the decoder.
- Carries LANES instructions per packet plus packet-level pc/badv/exception side-band.

Parameters:
- LANES, 2, instructions per packet (1..4).
- INST_W, 32, instruction width.
- ADDR_W, 32, pc/badv width.
- EXC_W, 7, exception code width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- flush  in  1  discard all held packets
- fifo_readygo  in  1  upstream packet valid
- fifo_allowin  out  1  stage can accept; registered, equals ~skid_valid
- in_inst  in  LANES*INST_W  lane i at bits [i*INST_W +: INST_W]
- in_lane_vld  in  LANES  per-lane valid mask
- in_pc  in  ADDR_W  pc of lane 0
- in_badv  in  ADDR_W  bad virtual address
- in_exception  in  EXC_W  exception code
- in_excp_flag  in  2  exception flag
- in_ibar_flag  in  2  ibar flag
- id_allowin  in  1  decoder accepts
- id_readygo  out  1  output packet valid
- out_inst  out  LANES*INST_W  held instructions
- out_lane_vld  out  LANES  held lane mask
- out_pc  out  ADDR_W  held pc
- out_badv  out  ADDR_W  held badv
- out_exception  out  EXC_W  held exception code
- out_excp_flag  out  2  held exception flag
- out_ibar_flag  out  2  held ibar flag

Behaviour:
- Reset (rstn=0 at a clk edge) and flush both produce the EMPTY state:
  - id_readygo=0, fifo_allowin=1, out_lane_vld=0
  - out_inst all lanes = `INST_NOP
  - out_pc=`PC_RESET, out_badv=`PC_RESET
  - out_exception=0, out_excp_flag=0, out_ibar_flag=0
- Storage is a main register (drives the outputs) plus a skid register. States:
  - EMPTY: nothing held.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Handshake:
  - Push = fifo_readygo & fifo_allowin.
  - Pop = id_readygo & id_allowin.
- Transitions:
  - EMPTY: push → ONE (main ← input).
  - ONE:
    - push & pop → ONE (main ← input).
    - push & !pop → TWO (skid ← input).
    - pop & !push → EMPTY.
  - TWO:
    - pop → ONE (main ← skid).
    - No push is possible, since fifo_allowin=0.
- Outputs and throughput:
  - Latency is 1 cycle from push to id_readygo.
  - Sustained throughput is 1 packet/cycle while id_allowin=1.
  - Outputs are stable while id_readygo=1 and id_allowin=0.
- Outputs in EMPTY are forced to the reset values above (NOP bubble), never stale data.
- Flush has priority over push and pop in the same cycle; the input is dropped. The next cycle is EMPTY with fifo_allowin=1.
- A packet with in_lane_vld=0 is still a valid packet (exception-only carrier) and is transferred normally.
- out_badv is captured from in_badv on every push.
- Every field is captured together; no partial updates.

Optional Feature:
- Macro FIFO_ID_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0].
  - perf_stall_cnt increments each cycle with id_readygo & !id_allowin.
  - perf_bubble_cnt increments each cycle with !id_readygo & id_allowin.
  - Both counters wrap at 2^32, are cleared by reset, and are not cleared by flush.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package/header `define.vh` holds `INST_NOP, `PC_RESET, and state encodings `FIDS_EMPTY=2'd0, `FIDS_ONE=2'd1, `FIDS_TWO=2'd2.
- One natural sub-module, fids_payload_reg: a generic width-parametrised enable/clear register instanced for the main and skid entries.
- Payload is packed into a single vector of width LANES*(INST_W+1) + 2*ADDR_W + EXC_W + 4.

Test Plan:
- Reset: hold rstn=0 for 2 cycles → id_readygo=0, fifo_allowin=1, out_inst={`INST_NOP,`INST_NOP}, out_pc=`PC_RESET.
- Streaming: push pc=0x1c000000, 0x1c000008, 0x1c000010 on consecutive cycles with id_allowin=1 → the same pcs appear on out_pc one cycle later each, with no bubbles.
- Backpressure: id_allowin=0 and two pushes (pc=0x100, 0x108) → fifo_allowin=0 after the second; release → 0x100 then 0x108 are output, none lost or duplicated.
- Flush in TWO with a concurrent fifo_readygo=1 (pc=0x200) → next cycle id_readygo=0, out_inst=NOP, fifo_allowin=1; 0x200 never appears.
- Lane mask and badv: push in_lane_vld=2'b01, in_badv=0xdeadbeef, in_exception=7'h08 → out_lane_vld=2'b01, out_badv=0xdeadbeef, out_exception=7'h08.
- With FIFO_ID_PERF_EN: 5 stall cycles then 3 idle cycles → perf_stall_cnt=5, perf_bubble_cnt=3; a flush leaves both unchanged.
